// File: rtl/mio_bus_ctrl.sv
// CPU memory/IO bus controller: decodes RAM, LED, switch and counter regions,
// sequences each access through IDLE -> BUSY -> DONE with a one-cycle ready strobe.
//
// state | meaning
// IDLE  | waiting for CPU_MIO; request latched on the accepting edge
// BUSY  | wait counter runs down; commit/capture on the edge where it is 0
// DONE  | MIO_ready high for this single cycle, then back to IDLE

module mio_bus_ctrl #(
    parameter int RAM_WAIT = 1,
    parameter int RAM_AW   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CPU_MIO,
    input  logic              MemRW,
    input  logic [31:0]       Addr_out,
    input  logic [31:0]       Data_out,
    output logic [31:0]       Data_in,
    output logic              MIO_ready,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    input  logic [15:0]       sw_in,
    output logic [15:0]       led_out
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [2:0] {RGN_RAM, RGN_LED, RGN_SW, RGN_CNT, RGN_NONE} rgn_t;

    localparam logic [3:0] WAIT_INIT = 4'(RAM_WAIT);

    state_t            state, state_nxt;
    rgn_t              rgn_dec, rgn_q;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic [RAM_AW-1:0] waddr_q;
    logic [3:0]        wait_cnt;
    logic [31:0]       counter;
    logic              accept, finish;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^Addr_out[1:0];
    assign ram_addr        = waddr_q;
    assign ram_din         = wdata_q;

    always_comb begin
        rgn_dec = RGN_NONE;
        if (Addr_out[31:12] == 20'h0)
            rgn_dec = RGN_RAM;
        else if (Addr_out[31:2] == 30'h3C00_0000)
            rgn_dec = RGN_LED;
        else if (Addr_out[31:2] == 30'h3C00_0001)
            rgn_dec = RGN_SW;
        else if (Addr_out[31:2] == 30'h3C00_0002)
            rgn_dec = RGN_CNT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        ram_we    = 1'b0;
        case (state)
            IDLE: begin
                if (CPU_MIO) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (wait_cnt == 4'd0) begin
                    finish    = 1'b1;
                    ram_we    = we_q && (rgn_q == RGN_RAM);
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch and wait counter; only RAM reads need the extra wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgn_q    <= RGN_NONE;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            waddr_q  <= '0;
            wait_cnt <= 4'd0;
        end else if (accept) begin
            rgn_q    <= rgn_dec;
            we_q     <= MemRW;
            wdata_q  <= Data_out;
            waddr_q  <= Addr_out[RAM_AW+1:2];
            wait_cnt <= (rgn_dec == RGN_RAM && !MemRW) ? WAIT_INIT : 4'd0;
        end else if (state == BUSY && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            MIO_ready <= 1'b0;
            Data_in   <= '0;
            led_out   <= '0;
            counter   <= '0;
        end else begin
            MIO_ready <= finish;
            if (finish && we_q && rgn_q == RGN_CNT)
                counter <= wdata_q;
            else
                counter <= counter + 32'd1;
            if (finish && we_q && rgn_q == RGN_LED)
                led_out <= wdata_q[15:0];
            // Read capture sees the counter value from before this edge.
            if (finish && !we_q) begin
                case (rgn_q)
                    RGN_RAM: Data_in <= ram_dout;
                    RGN_LED: Data_in <= {16'h0, led_out};
                    RGN_SW:  Data_in <= {16'h0, sw_in};
                    RGN_CNT: Data_in <= counter;
                    default: Data_in <= '0;
                endcase
            end
        end
    end

endmodule
